// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the sequencer state encoding and the width of the saturating debug counters.
package pll_seq_pkg;

   localparam int unsigned SAT_W = 8;

   typedef enum logic [1:0] {
      RESET,
      WAIT_LOCK,
      STABLE,
      RUN
   } pll_seq_state_t;

   // Debug counters stick at all-ones instead of wrapping.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Used for pll_locked here and for resets crossing into the outclk domains.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking, so sync_q takes the previous meta_q; blocking would merge both stages.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock acquisition with timeout/retry and lock-stability filtering,
// and drives the system reset that releases the rest of the design.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RESET_CYCLES        = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             soft_rst_req,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             ready,
   output logic [SAT_W-1:0] retry_count,
   output logic [SAT_W-1:0] lock_lost_count
);

   localparam int unsigned MAX_RS = (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RESET_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_RS > LOCK_TIMEOUT_CYCLES) ?
                                     MAX_RS : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_ALL) + 1;

   // cnt counts completed cycles in the current state, so each exit fires on the last one.
   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic             lock_s;
   pll_seq_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SAT_W-1:0] retry_q, retry_d;
   logic [SAT_W-1:0] lost_q, lost_d;
   logic             pll_rst_q;
   logic             sys_rst_n_q;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d_i   (pll_locked),
      .q_o   (lock_s)
   );

   always_comb begin
      // NOTE: every target gets a default first, so no path through the case can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      lost_d  = lost_q;

      if (soft_rst_req) begin
         state_d = RESET;
      end else begin
         case (state_q)
            RESET: begin
               if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d = RESET;
                  retry_d = sat_inc(retry_q);
               end
            end
            STABLE: begin
               if (!lock_s)                     state_d = WAIT_LOCK;
               else if (cnt_q == STABLE_LAST)   state_d = RUN;
            end
            RUN: begin
               if (!lock_s) begin
                  state_d = RESET;
                  lost_d  = sat_inc(lost_q);
               end
            end
            default: state_d = RESET;
         endcase
      end

      // A soft request inside RESET does not change state but must still restart the pulse.
      if (soft_rst_req || (state_d != state_q) || (state_q == RUN)) cnt_d = '0;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         lost_q      <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lost_q      <= lost_d;
         pll_rst_q   <= (state_d == RESET);
         sys_rst_n_q <= (state_d == RUN);
      end
   end

   assign pll_rst         = pll_rst_q;
   assign sys_rst_n       = sys_rst_n_q;
   assign ready           = sys_rst_n_q;
   assign retry_count     = retry_q;
   assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output events,
// a negedge monitor pops one whenever any output changes and compares cycle and values.
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst_req;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] retry_count;
   logic [7:0] lock_lost_count;

   pll_reset_sequencer #(
      .RESET_CYCLES        (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32)
   ) dut (
      .refclk          (refclk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .soft_rst_req    (soft_rst_req),
      .pll_rst         (pll_rst),
      .sys_rst_n       (sys_rst_n),
      .ready           (ready),
      .retry_count     (retry_count),
      .lock_lost_count (lock_lost_count)
   );

   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   // Bench time base: number of rising edges seen so far.
   int cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   typedef struct {
      string name;
      int    at;
      logic  prst;
      logic  srst;
      int    rc;
      int    lc;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input bit ok, input string got, input string want);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, got, want);
   endtask

   task automatic push(input string name, input int at, input logic prst, input logic srst,
                       input int rc, input int lc);
      ev_t e;
      e.name = name; e.at = at; e.prst = prst; e.srst = srst; e.rc = rc; e.lc = lc;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   // Monitor: any change in the output vector is one DUT event to be matched in order.
   initial begin
      logic [18:0] last_obs;
      logic [18:0] obs;
      ev_t         e;
      last_obs = 'x;
      forever begin
         @(negedge refclk);
         obs = {pll_rst, sys_rst_n, ready, retry_count, lock_lost_count};
         if (obs !== last_obs) begin
            last_obs = obs;
            if (exp_q.size() == 0) begin
               check("unexpected_change", 1'b0,
                     $sformatf("cyc=%0d pll_rst=%b sys_rst_n=%b ready=%b retry=%0d lost=%0d",
                               cyc, pll_rst, sys_rst_n, ready, retry_count, lock_lost_count),
                     "no output change");
            end else begin
               e = exp_q.pop_front();
               check(e.name,
                     (cyc == e.at) && (pll_rst === e.prst) && (sys_rst_n === e.srst) &&
                     (ready === e.srst) && (retry_count === 8'(e.rc)) &&
                     (lock_lost_count === 8'(e.lc)),
                     $sformatf("cyc=%0d pll_rst=%b sys_rst_n=%b ready=%b retry=%0d lost=%0d",
                               cyc, pll_rst, sys_rst_n, ready, retry_count, lock_lost_count),
                     $sformatf("cyc=%0d pll_rst=%b sys_rst_n=%b ready=%b retry=%0d lost=%0d",
                               e.at, e.prst, e.srst, e.srst, e.rc, e.lc));
            end
         end
      end
   end

   initial begin
      int rc;
      int rst_edge;
      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;

      // Clean start: 4-cycle pulse, lock 10 cycles later, release 2+1+8 edges after lock.
      push("reset_state",        1, 1'b1, 1'b0, 0, 0);
      push("clean_pll_rst_fall", 7, 1'b0, 1'b0, 0, 0);
      wait_cyc(3);  rst_n = 1'b1;
      wait_cyc(17); pll_locked = 1'b1;
      push("clean_release", 28, 1'b0, 1'b1, 0, 0);

      // Lock loss in RUN: reset 3 edges after the drop, then relock.
      wait_cyc(35); pll_locked = 1'b0;
      push("loss_enter_reset",  38, 1'b1, 1'b0, 0, 1);
      push("loss_pll_rst_fall", 42, 1'b0, 1'b0, 0, 1);
      wait_cyc(45); pll_locked = 1'b1;
      push("relock_release", 56, 1'b0, 1'b1, 0, 1);

      // Soft request in the same cycle the FSM sees the lock loss: no lost-count bump.
      wait_cyc(60); pll_locked = 1'b0;
      wait_cyc(62); soft_rst_req = 1'b1;
      push("soft_with_loss_reset", 63, 1'b1, 1'b0, 0, 1);
      push("soft_with_loss_fall",  67, 1'b0, 1'b0, 0, 1);
      wait_cyc(63); soft_rst_req = 1'b0;

      // One-cycle lock_s drop in STABLE restarts the 8-cycle count: release at 87, not 81.
      wait_cyc(70); pll_locked = 1'b1;
      push("unstable_release", 87, 1'b0, 1'b1, 0, 1);
      wait_cyc(75); pll_locked = 1'b0;
      wait_cyc(76); pll_locked = 1'b1;

      // Soft request in RUN, then another inside RESET restarts the full pulse.
      wait_cyc(90); soft_rst_req = 1'b1;
      push("soft_in_run_reset",   91, 1'b1, 1'b0, 0, 1);
      push("soft_restart_fall",   97, 1'b0, 1'b0, 0, 1);
      push("soft_restart_release",106, 1'b0, 1'b1, 0, 1);
      wait_cyc(91); soft_rst_req = 1'b0;
      wait_cyc(92); soft_rst_req = 1'b1;
      wait_cyc(93); soft_rst_req = 1'b0;

      // Lose lock and keep it off: 300 timeout retries, retry_count saturates at 255.
      wait_cyc(110); pll_locked = 1'b0;
      push("loss2_enter_reset",  113, 1'b1, 1'b0, 0, 2);
      push("loss2_pll_rst_fall", 117, 1'b0, 1'b0, 0, 2);
      for (int n = 1; n <= 300; n++) begin
         rc       = (n > 255) ? 255 : n;
         rst_edge = 149 + 36 * (n - 1);
         push($sformatf("timeout%0d_reset", n), rst_edge,     1'b1, 1'b0, rc, 2);
         push($sformatf("timeout%0d_fall",  n), rst_edge + 4, 1'b0, 1'b0, rc, 2);
      end
      wait_cyc(10920); pll_locked = 1'b1;
      push("post_retry_release", 10931, 1'b0, 1'b1, 255, 2);

      // Async reset while in STABLE, between clock edges.
      wait_cyc(10940); pll_locked = 1'b0;
      push("loss3_enter_reset",  10943, 1'b1, 1'b0, 255, 3);
      push("loss3_pll_rst_fall", 10947, 1'b0, 1'b0, 255, 3);
      wait_cyc(10950); pll_locked = 1'b1;
      wait_cyc(10956);
      push("async_reset_values", 10956, 1'b1, 1'b0, 0, 0);
      #3 rst_n = 1'b0;
      wait_cyc(10960); rst_n = 1'b1;
      push("after_async_fall",    10964, 1'b0, 1'b0, 0, 0);
      push("after_async_release", 10973, 1'b0, 1'b1, 0, 0);
      wait_cyc(10980);

      check("all_events_seen", exp_q.size() == 0,
            $sformatf("%0d pending", exp_q.size()), "0 pending");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
